lane_serializer: RTL
====================

# lane_serializer

- Parametrised successor to the team's fixed 32-to-4×8 word splitter.
- Accepts one DATA_W-bit word per valid/ready handshake and emits it as a sequence of LANE_W-bit lanes, one lane per output handshake.
- Emission order (MSB-first or LSB-first) and lane count are selected per word.
- Sits between a word-wide producer (register file or memory read port) and a narrow byte-oriented consumer (UART/display/store-byte path).

## Interface
- DATA_W, default 32: input word width; must be an integer multiple of LANE_W.
- LANE_W, default 8: output lane width.
- N (localparam) = DATA_W/LANE_W: lanes per word. CW (localparam) = $clog2(N+1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk edge.
- in_valid  in  1  producer offers a word.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DATA_W  word to split.
- in_msb_first  in  1  1: emit lane 0 first; 0: emit lane N-1 first. Sampled at accept.
- in_lanes  in  CW  number of lanes to emit, 1..N; 0 means N; values >N are treated as N. Sampled at accept.
- out_valid  out  1  out_data holds a valid lane.
- out_ready  in  1  consumer takes the lane.
- out_data  out  LANE_W  current lane.
- out_idx  out  CW  lane number of out_data within the word.
- out_last  out  1  current lane is the final one of this word.

## Operation
- Lane numbering: lane k = in_data[DATA_W-1-k*LANE_W -: LANE_W]. Lane 0 is the most significant lane, matching the O1..O4 ordering of the existing splitter.
- An accept occurs when in_valid && in_ready. An emit occurs when out_valid && out_ready.
- Two states:
  - IDLE: out_valid=0, in_ready=1. An accept loads the word register, order flag, and effective count L; the state goes to SEND with the emitted-lane counter cnt=0.
  - SEND: out_valid=1. out_idx = cnt when MSB-first, N-1-cnt when LSB-first. out_data = lane out_idx of the held word. out_last = (cnt == L-1).
- Transitions from SEND on an emit:
  - If !out_last: cnt increments by 1.
  - If out_last and in_valid is high: the new word is accepted in the same cycle and the block stays in SEND with cnt=0. There is no bubble.
  - If out_last and in_valid is low: the state goes to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). The producer may combinationally depend on in_ready, but out_ready must not depend on in_valid.
- Backpressure: while out_valid && !out_ready, out_data, out_idx, and out_last hold stable. In_data changes during SEND have no effect.
- in_valid while busy: ignored, except on the last-lane emit cycle described above.
- cnt is CW bits wide. It never exceeds L-1 and never wraps.

## Timing
- Reset values: state=IDLE, out_valid=0, in_ready=1 (the combinational result of IDLE), out_data=0, out_idx=0, out_last=0, cnt=0.
- Reset asserted mid-word: on the next edge the block returns to IDLE and drops remaining lanes. No partial word resumes.
- Latency: accept at edge t → first lane valid after edge t, so it is visible in cycle t+1.
- Throughput: with out_ready held high, a word of L lanes takes exactly L cycles. Back-to-back words stream with no idle cycle.
- L=1: a single lane, with out_last=1 on the first cycle.
- All outputs except in_ready are registered or decoded from registered state. in_ready has a combinational path from out_ready.

## Structure
- The shared package/header holds:
  - the state encodings ST_IDLE=1'b0 and ST_SEND=1'b1;
  - a function or macro computing effective L from in_lanes and N.
- One sub-module, lane_mux: a purely combinational select of lane k from a DATA_W word, parametrised by DATA_W and LANE_W. With default parameters it reproduces the old splitter's outputs.
- The top holds the FSM, cnt, the word/order/length registers, and handshake logic.

## Test plan
- Defaults, out_ready=1, in_data=32'h12345678, MSB-first, in_lanes=0 → out_data 12,34,56,78 on consecutive cycles; out_idx 0,1,2,3; out_last only with 78.
- Same word, in_msb_first=0 → 78,56,34,12; out_idx 3,2,1,0.
- Two words 32'hAABBCCDD then 32'h01020304 with in_valid held → 8 lanes in 8 consecutive cycles; in_ready high only in the DD cycle.
- out_ready toggled 1,0,0,1 during 32'hDEADBEEF → each lane held stable while stalled; sequence DE,AD,BE,EF unbroken.
- in_lanes=2, 32'h12345678, MSB-first → 12, then 34 with out_last=1, then IDLE. Repeat with in_lanes=7 → treated as 4.
- rst_n low for one cycle after lane 34 of 32'h12345678 → next cycle out_valid=0, in_ready=1; a new word starts at cnt=0.
- DATA_W=64, LANE_W=16, 64'h0011223344556677 LSB-first → 6677, 4455, 2233, 0011.

Source files
------------

// File: rtl/lane_serializer_pkg.sv
// Shared types and helpers for the word-to-lane serializer.
package lane_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Effective lane count: 0 or anything above n selects a full word.
   function automatic int unsigned eff_lanes(input int unsigned lanes, input int unsigned n);
      return ((lanes == 0) || (lanes > n)) ? n : lanes;
   endfunction

endpackage

// File: rtl/lane_serializer_if.sv
// Word-in / lane-out handshake bundle for lane_serializer.
interface lane_serializer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANE_W = 8
);
   localparam int unsigned N  = DATA_W / LANE_W;
   localparam int unsigned CW = $clog2(N + 1);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_msb_first;
   logic [CW-1:0]     in_lanes;
   logic              out_valid;
   logic              out_ready;
   logic [LANE_W-1:0] out_data;
   logic [CW-1:0]     out_idx;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, in_msb_first, in_lanes, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );

   modport master (
      output in_valid, in_data, in_msb_first, in_lanes, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/lane_serializer_lane_mux.sv
// Combinational select of lane sel from a word; lane 0 is the most significant.
module lane_mux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANE_W = 8
) (
   input  logic [DATA_W-1:0]                      word,
   input  logic [$clog2(DATA_W/LANE_W + 1)-1:0]   sel,
   output logic [LANE_W-1:0]                      lane
);
   localparam int unsigned N  = DATA_W / LANE_W;
   localparam int unsigned CW = $clog2(N + 1);

   always_comb begin
      lane = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (sel == CW'(k)) lane = word[DATA_W-1-k*LANE_W -: LANE_W];
      end
   end
endmodule

// File: rtl/lane_serializer.sv
// Splits one accepted word into 1..N lanes, MSB- or LSB-lane first, one per output handshake.
module lane_serializer
   import lane_serializer_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LANE_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   lane_serializer_if.slave bus
);
   localparam int unsigned N  = DATA_W / LANE_W;
   localparam int unsigned CW = $clog2(N + 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] word_q;
   logic              msb_q;
   logic [CW-1:0]     len_q;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     idx;
   logic              send, last, emit, accept;

   assign send   = (state_q == ST_SEND);
   assign last   = send && (cnt_q == (len_q - CW'(1)));
   assign emit   = send && bus.out_ready;
   assign accept = bus.in_valid && bus.in_ready;
   assign idx    = msb_q ? cnt_q : (CW'(N - 1) - cnt_q);

   // A last-lane emit frees the word register in the same cycle, so the next word streams in without a bubble.
   assign bus.in_ready  = !send || (emit && last);
   assign bus.out_valid = send;
   assign bus.out_idx   = idx;
   assign bus.out_last  = last;

   lane_mux #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_lane_mux (
      .word (word_q),
      .sel  (idx),
      .lane (bus.out_data)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (bus.in_valid) state_d = ST_SEND;
         ST_SEND: if (emit && last && !bus.in_valid) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         msb_q   <= 1'b1;
         len_q   <= CW'(N);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            word_q <= bus.in_data;
            msb_q  <= bus.in_msb_first;
            len_q  <= CW'(eff_lanes(32'(bus.in_lanes), N));
            cnt_q  <= '0;
         end else if (emit) begin
            cnt_q <= last ? '0 : (cnt_q + CW'(1));
         end
      end
   end
endmodule
